// File: rtl/tdc_delay_line.sv
// Tapped inverter-chain TDC: launches an edge, snapshots every tap one clock later and serially
// encodes the thermometer count. Define TDC_ACCUM_EN to sum 2**ACC_LOG2 auto-relaunched shots.
module tdc_delay_line #(
  parameter int STAGES    = 34,
  parameter int DRAIN_CYC = 8,
  parameter int ACC_LOG2  = 2,
  localparam int CNT_W    = $clog2(STAGES + 1),
`ifdef TDC_ACCUM_EN
  localparam int OUT_W    = CNT_W + ACC_LOG2
`else
  localparam int OUT_W    = CNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inj_en,
  input  logic [STAGES-1:0] inj_taps,
  output logic              busy,
  output logic              valid,
  output logic [OUT_W-1:0]  count,
  output logic              overflow,
  output logic [STAGES-1:0] snap
);

  localparam int IDX_W = $clog2(STAGES);
  localparam int DRW   = $clog2(DRAIN_CYC + 2);

  typedef enum logic [2:0] {IDLE, CAPTURE, SCAN, DONE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic                launch_q, launch_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [OUT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [STAGES-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic                run_q, run_d;
  logic [DRW-1:0]      drain_q, drain_d;

`ifdef TDC_ACCUM_EN
  localparam int SHOTS  = 1 << ACC_LOG2;
  localparam int SHOT_W = ACC_LOG2 + 1;
  logic [OUT_W-1:0]  sum_q, sum_d, sum_nx;
  logic [SHOT_W-1:0] shot_q, shot_d;
  logic              ovf_acc_q, ovf_acc_d, ovf_nx;
`endif

  logic [STAGES-1:0] raw;
  logic [STAGES-1:0] norm;

  // Each stage is its own kept net so the chain survives synthesis as real inverters.
  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    (* keep = "true" *) logic inv;
    if (i == 0) begin : g_first
      assign inv = ~launch_q;
    end else begin : g_next
      assign inv = ~g_stg[i-1].inv;
    end
    assign raw[i] = inv;
    if (i % 2 == 1) begin : g_odd
      assign norm[i] = raw[i];
    end else begin : g_even
      assign norm[i] = ~raw[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    launch_d = launch_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    count_d  = count_q;
    ovf_d    = ovf_q;
    snap_d   = snap_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    run_d    = run_q;
    drain_d  = drain_q;
`ifdef TDC_ACCUM_EN
    sum_d     = sum_q;
    shot_d    = shot_q;
    ovf_acc_d = ovf_acc_q;
    sum_nx    = sum_q + OUT_W'(acc_q);
    ovf_nx    = ovf_acc_q | (acc_q == CNT_W'(STAGES));
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          launch_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = CAPTURE;
`ifdef TDC_ACCUM_EN
          sum_d     = '0;
          shot_d    = '0;
          ovf_acc_d = 1'b0;
`endif
        end
      end
      CAPTURE: begin
        snap_d   = inj_en ? inj_taps : norm;
        launch_d = 1'b0;
        idx_d    = '0;
        acc_d    = '0;
        run_d    = 1'b1;
        state_d  = SCAN;
      end
      SCAN: begin
        // Count stops at the first zero; later bubbles are ignored.
        if (run_q && snap_q[idx_q]) begin
          acc_d = acc_q + CNT_W'(1);
        end else begin
          run_d = 1'b0;
        end
        if (idx_q == IDX_W'(STAGES - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        drain_d = DRW'(DRAIN_CYC);
        state_d = DRAIN;
`ifdef TDC_ACCUM_EN
        sum_d     = sum_nx;
        ovf_acc_d = ovf_nx;
        shot_d    = shot_q + SHOT_W'(1);
        if (shot_q == SHOT_W'(SHOTS - 1)) begin
          count_d = sum_nx;
          ovf_d   = ovf_nx;
          valid_d = 1'b1;
        end
`else
        count_d = acc_q;
        ovf_d   = (acc_q == CNT_W'(STAGES));
        valid_d = 1'b1;
`endif
      end
      DRAIN: begin
        if (drain_q == '0) begin
`ifdef TDC_ACCUM_EN
          if (shot_q != SHOT_W'(SHOTS)) begin
            launch_d = 1'b1;
            state_d  = CAPTURE;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end else begin
          drain_d = drain_q - DRW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      snap_q   <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      run_q    <= 1'b0;
      drain_q  <= '0;
`ifdef TDC_ACCUM_EN
      sum_q     <= '0;
      shot_q    <= '0;
      ovf_acc_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      run_q    <= run_d;
      drain_q  <= drain_d;
`ifdef TDC_ACCUM_EN
      sum_q     <= sum_d;
      shot_q    <= shot_d;
      ovf_acc_q <= ovf_acc_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign snap     = snap_q;

endmodule

// File: tb/tb_tdc_delay_line.sv
// Directed bench for tdc_delay_line: injected and chain-driven measurements, timing, resets.
`timescale 1ns/1ps
module tb_tdc_delay_line;
  localparam int S  = 34;
  localparam int CW = $clog2(S + 1);
`ifdef TDC_ACCUM_EN
  localparam int OW    = CW + 2;
  localparam int SHOTS = 4;
`else
  localparam int OW    = CW;
  localparam int SHOTS = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          inj_en;
  logic [S-1:0]  inj_taps;
  logic          busy;
  logic          valid;
  logic [OW-1:0] count;
  logic          overflow;
  logic [S-1:0]  snap;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tdc_delay_line #(
    .STAGES   (S),
    .DRAIN_CYC(8),
    .ACC_LOG2 (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .inj_en  (inj_en),
    .inj_taps(inj_taps),
    .busy    (busy),
    .valid   (valid),
    .count   (count),
    .overflow(overflow),
    .snap    (snap)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input string tag, input logic ie, input logic [S-1:0] taps,
                         input int exp1, input logic exp_ovf, input logic poke);
    int cyc;
    int d;
    int extra;
    logic [S-1:0] exp_snap;
    exp_snap = ie ? taps : {S{1'b1}};
    inj_en   = ie;
    inj_taps = taps;
    start    = 1'b1;
    tick;
    start = 1'b0;
    cyc   = 0;
    while (!valid && cyc < 400) begin
      start = (poke && (cyc == 5 || cyc == 20)) ? 1'b1 : 1'b0;
      tick;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_valid_seen"}, 64'(valid), 64'd1);
`ifndef TDC_ACCUM_EN
    chk({tag, "_latency"}, 64'(cyc), 64'(S + 2));
`endif
    chk({tag, "_count"}, 64'(count), 64'(exp1 * SHOTS));
    chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    chk({tag, "_snap"}, 64'(snap), 64'(exp_snap));
    d     = 0;
    extra = 0;
    while (busy && d < 400) begin
      start = (poke && d == 3) ? 1'b1 : 1'b0;
      tick;
      d++;
      if (valid) extra++;
    end
    start = 1'b0;
    chk({tag, "_busy_fall"}, 64'(d), 64'd9);
    repeat (4) begin
      tick;
      if (valid) extra++;
    end
    chk({tag, "_extra_valid"}, 64'(extra), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int nv;
    logic [S-1:0] ones;
    ones     = {S{1'b1}};
    rst      = 1'b1;
    start    = 1'b0;
    inj_en   = 1'b0;
    inj_taps = '0;
    tick;
    tick;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_snap", 64'(snap), 64'd0);
    rst = 1'b0;
    tick;

    measure("ff", 1'b1, 34'h0_0000_00FF, 8, 1'b0, 1'b0);
    repeat (10) tick;
    chk("hold_count", 64'(count), 64'(8 * SHOTS));
    chk("hold_ovf", 64'(overflow), 64'd0);
    measure("bubble", 1'b1, 34'h0_0000_00EF, 4, 1'b0, 1'b0);
    measure("zeros", 1'b1, 34'h0, 0, 1'b0, 1'b0);
    measure("ones", 1'b1, ones, 34, 1'b1, 1'b0);
    measure("chain", 1'b0, 34'h0_0000_0F0F, 34, 1'b1, 1'b1);

    // Reset while scanning tap 10: partial result must vanish without a valid.
    inj_en   = 1'b1;
    inj_taps = 34'h0_0000_00FF;
    start    = 1'b1;
    tick;
    start = 1'b0;
    repeat (11) tick;
    chk("scan_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("scanrst_busy", 64'(busy), 64'd0);
    chk("scanrst_count", 64'(count), 64'd0);
    chk("scanrst_ovf", 64'(overflow), 64'd0);
    chk("scanrst_snap", 64'(snap), 64'd0);
    nv = 0;
    repeat (50) begin
      tick;
      if (valid) nv++;
    end
    chk("scanrst_no_valid", 64'(nv), 64'd0);
    chk("scanrst_count_held", 64'(count), 64'd0);
    measure("after_rst", 1'b1, 34'h0_0000_00FF, 8, 1'b0, 1'b0);

    // Reset during drain clears the finished result.
    inj_taps = ones;
    start    = 1'b1;
    tick;
    start = 1'b0;
    nv    = 0;
    while (!valid && nv < 400) begin
      tick;
      nv++;
    end
    chk("drain_valid_seen", 64'(valid), 64'd1);
    tick;
    tick;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk("drainrst_busy", 64'(busy), 64'd0);
    chk("drainrst_count", 64'(count), 64'd0);
    chk("drainrst_ovf", 64'(overflow), 64'd0);
    chk("drainrst_valid", 64'(valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
